pulse_train_gen: RTL

Multi-channel, parametrised successor to the single-shot pulse-width generator. Each channel emits a programmable train of pulses: high width, low gap and repeat count, with continuous mode and abort. A shared config port with a valid/ready handshake writes per-channel shadow registers. The block sits behind the top-level pin wrapper, driven from ui_in/uio and observed on uo_out.

---
 rtl/pulse_train_pkg.sv | 28 ++
 rtl/pulse_train_channel.sv | 99 +++++++++
 rtl/pulse_train_gen.sv | 81 ++++++++
 3 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types and default sizing for the multi-channel pulse train generator.
// Optional feature macro: PULSE_TRAIN_PRESCALE_EN (shared tick prescaler).
package pulse_train_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_W          = 8;
  localparam int DEF_RPT_W      = 4;
  localparam int DEF_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } pt_state_e;

  // Channel programming at default widths; rpt = 0 means continuous.
  typedef struct packed {
    logic [DEF_W-1:0]     high;
    logic [DEF_W-1:0]     low;
    logic [DEF_RPT_W-1:0] rpt;
  } ch_cfg_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_train_channel.sv
// One pulse-train channel: shadow config, active copy latched at start,
// phase/repeat counters and the IDLE/HIGH/LOW/DONE sequencer.
module pulse_train_channel
  import pulse_train_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int RPT_W = DEF_RPT_W
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_wr,
  input  logic [W-1:0]     i_high,
  input  logic [W-1:0]     i_low,
  input  logic [RPT_W-1:0] i_rpt,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_done
);

  pt_state_e        r_state, w_next;
  logic [W-1:0]     r_sh_high, r_sh_low, r_act_high, r_act_low, r_cnt;
  logic [RPT_W-1:0] r_sh_rpt, r_act_rpt, r_rem;
  logic             w_launch, w_phase_end, w_cont, w_last;

  assign w_launch    = (r_state == S_IDLE) & i_start & ~i_abort;
  assign w_phase_end = i_tick & (r_cnt <= W'(1));
  assign w_cont      = (r_act_rpt == '0);
  assign w_last      = ~w_cont & (r_rem == RPT_W'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_launch) w_next = (r_sh_high != '0) ? S_HIGH : S_DONE;
      S_HIGH: begin
        if (i_abort)          w_next = S_IDLE;
        else if (w_phase_end) begin
          if (w_last)                w_next = S_DONE;
          else if (r_act_low != '0)  w_next = S_LOW;
          else                       w_next = S_HIGH;
        end
      end
      S_LOW: begin
        if (i_abort)          w_next = S_IDLE;
        else if (w_phase_end) w_next = S_HIGH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // The active copy isolates a running train from later shadow writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_high  <= '0;
      r_sh_low   <= '0;
      r_sh_rpt   <= '0;
      r_act_high <= '0;
      r_act_low  <= '0;
      r_act_rpt  <= '0;
      r_cnt      <= '0;
      r_rem      <= '0;
    end else begin
      if (i_wr) begin
        r_sh_high <= i_high;
        r_sh_low  <= i_low;
        r_sh_rpt  <= i_rpt;
      end
      if (w_launch) begin
        r_act_high <= r_sh_high;
        r_act_low  <= r_sh_low;
        r_act_rpt  <= r_sh_rpt;
        r_cnt      <= r_sh_high;
        r_rem      <= r_sh_rpt;
      end else if (r_state == S_HIGH && !i_abort) begin
        if (w_phase_end) begin
          if (!w_cont) r_rem <= r_rem - RPT_W'(1);
          r_cnt <= (r_act_low != '0) ? r_act_low : r_act_high;
        end else if (i_tick) begin
          r_cnt <= r_cnt - W'(1);
        end
      end else if (r_state == S_LOW && !i_abort) begin
        if (w_phase_end) r_cnt <= r_act_high;
        else if (i_tick) r_cnt <= r_cnt - W'(1);
      end
    end
  end

  assign o_pulse = (r_state == S_HIGH);
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator: config handshake/decode and channel array.
// Optional PULSE_TRAIN_PRESCALE_EN adds a shared prescaler gating phase counters.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int W          = DEF_W,
  parameter int RPT_W      = DEF_RPT_W,
`ifdef PULSE_TRAIN_PRESCALE_EN
  parameter int PRESCALE_W = DEF_PRESCALE_W,
`endif
  parameter int CH_W       = ch_idx_w(NUM_CH)
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [W-1:0]          cfg_high,
  input  logic [W-1:0]          cfg_low,
  input  logic [RPT_W-1:0]      cfg_repeat,
`ifdef PULSE_TRAIN_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  input  logic [NUM_CH-1:0]     start,
  input  logic [NUM_CH-1:0]     abort,
  output logic [NUM_CH-1:0]     pulse_out,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     done
);

  logic              w_tick;
  logic              w_ready;
  logic [NUM_CH-1:0] w_wr;

`ifdef PULSE_TRAIN_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_div;

  // >= keeps the divider sane if prescale is lowered mid-count.
  assign w_tick = (r_div >= prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + PRESCALE_W'(1);
  end
`else
  assign w_tick = 1'b1;
`endif

  // Out-of-range channels read as ready so the write is silently dropped.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_W'(i)) w_ready = ~busy[i];
  end
  assign cfg_ready = w_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = cfg_valid & w_ready & (cfg_ch == CH_W'(g));

    pulse_train_channel #(
      .W     (W),
      .RPT_W (RPT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (reset),
      .i_tick  (w_tick),
      .i_wr    (w_wr[g]),
      .i_high  (cfg_high),
      .i_low   (cfg_low),
      .i_rpt   (cfg_repeat),
      .i_start (start[g]),
      .i_abort (abort[g]),
      .o_pulse (pulse_out[g]),
      .o_busy  (busy[g]),
      .o_done  (done[g])
    );
  end

endmodule
